sum_sequencer: RTL

SUM_SEQUENCER -- requirements
Module: sum_sequencer

---
 rtl/sum_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sum_sequencer.sv
// sum_sequencer
// Computes 1 + 2 + ... + N using an external 4-entry register file as its
// datapath. The register allocation is fixed:
//   R0 = zero, R1 = counter i, R2 = running sum, R3 = limit N.
// One register-file operation is issued per state. The result is mirrored
// into oSum. oOverflow is a sticky flag that records any carry out of the
// sum; it is cleared when the next run is accepted.
//
// Ports
//   iClk                  single clock, rising edge
//   iRst_n                synchronous active-low reset
//   iStart                start request, honoured only in IDLE
//   iLimit[DATA_W]        N, captured when a start is accepted
//   oBusy / oDone         not-IDLE / one-cycle completion strobe
//   oSum / oOverflow      result (wraps modulo 2^DATA_W) and sticky carry
//   oWrEn/oWrAddr/oWrData register-file write port
//   oRdAddr0/1, iRdData0/1 two combinational register-file read ports
//
// State table
//   state   | meaning
//   IDLE    | wait for iStart; latch limit and clear overflow on accept
//   LD_LIM  | R3 <= latched limit
//   CLR_SUM | R2 <= R0 + R0 (zero); oSum <= 0
//   INIT_I  | R1 <= 1; go to DONE when the limit is zero
//   ADD     | R2 <= R2 + R1; oSum follows; carry sets overflow
//   CMP     | compare R1 with R3; equal ends the loop
//   INC     | R1 <= R1 + 1
//   DONE    | oDone for one cycle, then back to IDLE
module sum_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iLimit,
    output logic              oBusy,
    output logic              oDone,
    output logic [DATA_W-1:0] oSum,
    output logic              oOverflow,
    output logic              oWrEn,
    output logic [1:0]        oWrAddr,
    output logic [DATA_W-1:0] oWrData,
    output logic [1:0]        oRdAddr0,
    output logic [1:0]        oRdAddr1,
    input  logic [DATA_W-1:0] iRdData0,
    input  logic [DATA_W-1:0] iRdData1
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_LIM  = 3'd1;
    localparam logic [2:0] S_CLR_SUM = 3'd2;
    localparam logic [2:0] S_INIT_I  = 3'd3;
    localparam logic [2:0] S_ADD     = 3'd4;
    localparam logic [2:0] S_CMP     = 3'd5;
    localparam logic [2:0] S_INC     = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [1:0] R_ZERO  = 2'd0;
    localparam logic [1:0] R_I     = 2'd1;
    localparam logic [1:0] R_SUM   = 2'd2;
    localparam logic [1:0] R_LIMIT = 2'd3;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_limit;
    logic [DATA_W-1:0] r_sum;
    logic              r_ovf;

    logic [2:0]        w_next;
    logic              w_we;
    logic [1:0]        w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [1:0]        w_ra0;
    logic [1:0]        w_ra1;
    logic [DATA_W:0]   w_add;
    logic [DATA_W-1:0] w_inc;

    // One extra bit so the carry out of the sum is visible for the overflow flag.
    assign w_add = {1'b0, iRdData0} + {1'b0, iRdData1};
    assign w_inc = iRdData0 + DATA_W'(1);

    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_waddr = R_ZERO;
        w_wdata = '0;
        w_ra0   = R_ZERO;
        w_ra1   = R_ZERO;
        case (r_state)
            S_IDLE: begin
                if (iStart) w_next = S_LD_LIM;
            end
            S_LD_LIM: begin
                w_we    = 1'b1;
                w_waddr = R_LIMIT;
                w_wdata = r_limit;
                w_next  = S_CLR_SUM;
            end
            S_CLR_SUM: begin
                w_we    = 1'b1;
                w_waddr = R_SUM;
                w_wdata = w_add[DATA_W-1:0];
                w_next  = S_INIT_I;
            end
            S_INIT_I: begin
                w_we    = 1'b1;
                w_waddr = R_I;
                w_wdata = DATA_W'(1);
                w_next  = (r_limit == '0) ? S_DONE : S_ADD;
            end
            S_ADD: begin
                w_ra0   = R_SUM;
                w_ra1   = R_I;
                w_we    = 1'b1;
                w_waddr = R_SUM;
                w_wdata = w_add[DATA_W-1:0];
                w_next  = S_CMP;
            end
            S_CMP: begin
                w_ra0  = R_I;
                w_ra1  = R_LIMIT;
                w_next = (iRdData0 == iRdData1) ? S_DONE : S_INC;
            end
            S_INC: begin
                w_ra0   = R_I;
                w_we    = 1'b1;
                w_waddr = R_I;
                w_wdata = w_inc;
                w_next  = S_ADD;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
            r_limit <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_limit <= iLimit;
                        r_ovf   <= 1'b0;
                    end
                end
                S_CLR_SUM: begin
                    r_sum <= '0;
                end
                S_ADD: begin
                    r_sum <= w_add[DATA_W-1:0];
                    if (w_add[DATA_W]) r_ovf <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign oBusy     = (r_state != S_IDLE);
    assign oDone     = (r_state == S_DONE);
    assign oSum      = r_sum;
    assign oOverflow = r_ovf;

    // The write port is suppressed while reset is asserted, so the edge that
    // aborts a run cannot also commit that run's pending write.
    assign oWrEn    = w_we & iRst_n;
    assign oWrAddr  = oWrEn ? w_waddr : R_ZERO;
    assign oWrData  = oWrEn ? w_wdata : '0;
    assign oRdAddr0 = w_ra0;
    assign oRdAddr1 = w_ra1;

endmodule
